// File: rtl/updi_response_handler.sv
// UPDI receive-side handler: drops TX echoes, collects response bytes, checks the ACK.
// One FIFO read per two cycles; result pulses are registered and appear one cycle after the deciding byte.
module updi_response_handler #(
  parameter int MAX_DATA_SIZE  = 16,
  parameter int LEN_BITS       = $clog2(MAX_DATA_SIZE + 1),
  parameter int DISCARD_BITS   = 6,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         ready,
  input  logic [DISCARD_BITS-1:0]      discard_len,
  input  logic [LEN_BITS-1:0]          resp_len,
  input  logic                         expect_ack,
  input  logic [7:0]                   fifo_data,
  output logic                         fifo_rd_en,
  input  logic                         fifo_empty,
  output logic [8*MAX_DATA_SIZE-1:0]   data,
  output logic [LEN_BITS-1:0]          rx_count,
  output logic                         ack_received,
  output logic                         done,
  output logic                         err_bad_ack,
  output logic                         err_timeout
);

  localparam int TMO_BITS = $clog2(TIMEOUT_CYCLES);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DISCARD = 2'd1;
  localparam logic [1:0] S_DATA    = 2'd2;
  localparam logic [1:0] S_ACK     = 2'd3;
  localparam logic [LEN_BITS-1:0] MAX_LEN  = LEN_BITS'(MAX_DATA_SIZE);
  localparam logic [TMO_BITS-1:0] TMO_LAST = TMO_BITS'(TIMEOUT_CYCLES - 2);

  logic [1:0]                        state_q, state_d;
  logic [DISCARD_BITS-1:0]           disc_q, disc_d;
  logic [LEN_BITS-1:0]               len_q, len_d;
  logic                              ack_en_q, ack_en_d;
  logic [LEN_BITS-1:0]               rx_count_q, rx_count_d;
  logic [MAX_DATA_SIZE-1:0][7:0]     data_q, data_d;
  logic                              pend_q, pend_d;
  logic [TMO_BITS-1:0]               tmo_q, tmo_d;
  logic                              ack_q, ack_d;
  logic                              done_q, done_d;
  logic                              bad_q, bad_d;
  logic                              tmo_err_q, tmo_err_d;

  logic                active;
  logic                consume;
  logic                tmo_hit;
  logic [LEN_BITS-1:0] len_clamped;

  assign active      = (state_q != S_IDLE);
  assign consume     = active && pend_q;
  // The cycle that times out must not pop another byte, it would be lost silently.
  assign tmo_hit     = active && !consume && (tmo_q == TMO_LAST);
  assign fifo_rd_en  = active && !pend_q && !fifo_empty && !tmo_hit;
  assign len_clamped = (resp_len > MAX_LEN) ? MAX_LEN : resp_len;

  assign ready        = (state_q == S_IDLE);
  assign data         = data_q;
  assign rx_count     = rx_count_q;
  assign ack_received = ack_q;
  assign done         = done_q;
  assign err_bad_ack  = bad_q;
  assign err_timeout  = tmo_err_q;

  always_comb begin
    state_d    = state_q;
    disc_d     = disc_q;
    len_d      = len_q;
    ack_en_d   = ack_en_q;
    rx_count_d = rx_count_q;
    data_d     = data_q;
    pend_d     = pend_q;
    tmo_d      = tmo_q;
    ack_d      = 1'b0;
    done_d     = 1'b0;
    bad_d      = 1'b0;
    tmo_err_d  = 1'b0;

    if (fifo_rd_en) begin
      pend_d = 1'b1;
    end else if (consume) begin
      pend_d = 1'b0;
    end
    if (active) begin
      tmo_d = consume ? '0 : tmo_q + TMO_BITS'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          disc_d     = discard_len;
          len_d      = len_clamped;
          ack_en_d   = expect_ack;
          rx_count_d = '0;
          tmo_d      = '0;
          pend_d     = 1'b0;
          if (discard_len != '0) begin
            state_d = S_DISCARD;
          end else if (len_clamped != '0) begin
            state_d = S_DATA;
          end else if (expect_ack) begin
            state_d = S_ACK;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_DISCARD: begin
        if (consume) begin
          disc_d = disc_q - DISCARD_BITS'(1);
          if (disc_q == DISCARD_BITS'(1)) begin
            if (len_q != '0) begin
              state_d = S_DATA;
            end else if (ack_en_q) begin
              state_d = S_ACK;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_DATA: begin
        if (consume) begin
          for (int i = 0; i < MAX_DATA_SIZE; i++) begin
            if (LEN_BITS'(i) == rx_count_q) begin
              data_d[i] = fifo_data;
            end
          end
          rx_count_d = rx_count_q + LEN_BITS'(1);
          if (rx_count_q + LEN_BITS'(1) == len_q) begin
            if (ack_en_q) begin
              state_d = S_ACK;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_ACK: begin
        if (consume) begin
          state_d = S_IDLE;
          if (fifo_data == 8'h40) begin
            ack_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (tmo_hit) begin
      state_d   = S_IDLE;
      pend_d    = 1'b0;
      tmo_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      disc_q     <= '0;
      len_q      <= '0;
      ack_en_q   <= 1'b0;
      rx_count_q <= '0;
      data_q     <= '0;
      pend_q     <= 1'b0;
      tmo_q      <= '0;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      bad_q      <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      disc_q     <= disc_d;
      len_q      <= len_d;
      ack_en_q   <= ack_en_d;
      rx_count_q <= rx_count_d;
      data_q     <= data_d;
      pend_q     <= pend_d;
      tmo_q      <= tmo_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      bad_q      <= bad_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

endmodule

// File: tb/tb_updi_response_handler.sv
// Bench for updi_response_handler: queue-based RX FIFO, segment-level outcome model, per-cycle compare.
module tb_updi_response_handler;
  localparam int T = 1024;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   discard_len = '0;
  logic [4:0]   resp_len = '0;
  logic         expect_ack = 1'b0;
  logic [7:0]   fifo_data = '0;
  logic         fifo_empty = 1'b1;
  logic         ready, fifo_rd_en, ack_received, done, err_bad_ack, err_timeout;
  logic [127:0] data;
  logic [4:0]   rx_count;

  updi_response_handler dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .discard_len(discard_len), .resp_len(resp_len), .expect_ack(expect_ack),
    .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty),
    .data(data), .rx_count(rx_count), .ack_received(ack_received), .done(done),
    .err_bad_ack(err_bad_ack), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] seg_bytes[$];
  logic [7:0] exp_mem[16];
  int         exp_cnt = 0;
  logic [3:0] exp_pulses = '0;
  bit         exp_tmo = 0;
  bit         seg_active = 0;
  int         cyc = 0;
  int         last_ev = 0;
  int         n_ack = 0, n_done = 0, n_bad = 0, n_tmo = 0;
  logic [3:0] pulses;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [127:0] exp_flat();
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[i*8 +: 8] = exp_mem[i];
    return f;
  endfunction

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic flush();
    fifo_q.delete();
    fifo_empty = 1'b1;
  endtask

  // RX FIFO model: data appears the cycle after a read strobe.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
      #1 fifo_empty = (fifo_q.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      cyc++;
      chk("rd_while_empty", fifo_rd_en && fifo_empty, 0);
      if (seg_active && fifo_rd_en) last_ev = cyc + 1;
      pulses = {ack_received, done, err_bad_ack, err_timeout};
      if (ack_received) n_ack++;
      if (done) n_done++;
      if (err_bad_ack) n_bad++;
      if (err_timeout) n_tmo++;
      if (pulses != 0) begin
        if (!seg_active) begin
          chk("spurious_pulse", pulses, 0);
        end else begin
          chk("pulse_kind", pulses, exp_pulses);
          chk("pulse_cycle", cyc, exp_tmo ? last_ev + T : last_ev + 1);
          chk("rx_count", rx_count, exp_cnt);
          chk("data", data, exp_flat());
          seg_active = 0;
        end
      end else if (seg_active && cyc > last_ev + T + 4) begin
        chk("segment_hang", 1, 0);
        seg_active = 0;
      end
      chk("ready", ready, !seg_active);
      if (start && ready) begin
        seg_active = 1;
        last_ev = cyc;
      end
    end
  end

  task automatic run_seg(input int disc, input int len, input bit ack, input bit preload, input bit poke);
    int clen, need, n, ncons;
    n = seg_bytes.size();
    clen = (len > 16) ? 16 : len;
    need = disc + clen + (ack ? 1 : 0);
    ncons = (n < need) ? n : need;
    exp_cnt = (ncons > disc) ? ncons - disc : 0;
    if (exp_cnt > clen) exp_cnt = clen;
    for (int i = 0; i < exp_cnt; i++) exp_mem[i] = seg_bytes[disc + i];
    exp_tmo = (n < need);
    if (n < need) exp_pulses = 4'b0001;
    else if (ack) exp_pulses = (seg_bytes[disc + clen] == 8'h40) ? 4'b1100 : 4'b0010;
    else exp_pulses = 4'b0100;
    if (preload) foreach (seg_bytes[i]) push(seg_bytes[i]);
    discard_len = 6'(disc);
    resp_len = 5'(len);
    expect_ack = ack;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    if (!preload) begin
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
        push(seg_bytes[i]);
        if (poke && i == 1) begin
          start = 1'b1;
          discard_len = 6'($urandom_range(0, 63));
          resp_len = 5'($urandom_range(0, 31));
          expect_ack = ~ack;
          @(posedge clk); #2;
          start = 1'b0;
        end
      end
    end
    for (int k = 0; k < 3000 && seg_active; k++) begin @(posedge clk); #2; end
    chk("seg_complete", seg_active, 0);
    chk("fifo_left", fifo_q.size(), n - ncons);
    flush();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, d0, b0, t0;
    logic [127:0] sib;
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_ready", ready, 1);
    chk("reset_rd_en", fifo_rd_en, 0);
    chk("reset_pulses", {ack_received, done, err_bad_ack, err_timeout}, 0);
    chk("reset_rx_count", rx_count, 0);
    chk("reset_data", data, 0);
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #2; end

    // Echo drop then ACK
    a0 = n_ack; d0 = n_done;
    seg_bytes = '{8'h55, 8'h44, 8'h40};
    run_seg(2, 0, 1, 1, 0);
    chk("t1_ack_count", n_ack - a0, 1);
    chk("t1_done_count", n_done - d0, 1);
    chk("t1_rx_count", rx_count, 0);
    chk("t1_ready", ready, 1);

    // LDCS
    a0 = n_ack; d0 = n_done;
    seg_bytes = '{8'h55, 8'h80, 8'h30};
    run_seg(2, 1, 0, 1, 0);
    chk("t2_data0", data[7:0], 8'h30);
    chk("t2_rx_count", rx_count, 1);
    chk("t2_done_count", n_done - d0, 1);
    chk("t2_ack_count", n_ack - a0, 0);

    // SIB, trickled
    seg_bytes = '{8'h55, 8'hE5};
    for (int i = 0; i < 16; i++) seg_bytes.push_back(8'(i));
    run_seg(2, 16, 0, 0, 1);
    for (int i = 0; i < 16; i++) sib[i*8 +: 8] = 8'(i);
    chk("t3_data", data, sib);
    chk("t3_rx_count", rx_count, 16);
    chk("t3_fifo_empty", fifo_empty, 1);

    // Bad ACK
    a0 = n_ack; d0 = n_done; b0 = n_bad;
    seg_bytes = '{8'h41};
    run_seg(0, 0, 1, 1, 0);
    chk("t4_bad_count", n_bad - b0, 1);
    chk("t4_ack_count", n_ack - a0, 0);
    chk("t4_done_count", n_done - d0, 0);
    chk("t4_ready", ready, 1);

    // Starved FIFO
    t0 = n_tmo;
    seg_bytes = '{8'hAA};
    run_seg(0, 2, 0, 0, 0);
    chk("t5_data0", data[7:0], 8'hAA);
    chk("t5_rx_count", rx_count, 1);
    chk("t5_tmo_count", n_tmo - t0, 1);
    chk("t5_ready", ready, 1);

    // Busy start ignored, then reset mid-DATA
    exp_tmo = 0; exp_pulses = 4'b0100; exp_cnt = 16;
    discard_len = 6'd0; resp_len = 5'd20; expect_ack = 1'b0; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    push(8'hAA); repeat (2) begin @(posedge clk); #2; end
    push(8'hBB); repeat (2) begin @(posedge clk); #2; end
    discard_len = 6'd3; resp_len = 5'd1; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    push(8'hCC); repeat (3) begin @(posedge clk); #2; end
    chk("busy_start_ignored", rx_count, 3);
    chk("busy_ready", ready, 0);
    rst = 1'b0;
    #1;
    chk("arst_ready", ready, 1);
    chk("arst_rx_count", rx_count, 0);
    chk("arst_data", data, 0);
    chk("arst_rd_en", fifo_rd_en, 0);
    seg_active = 0;
    flush();
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;

    // Clamp: resp_len 20 collects 16, leaves 4 in the FIFO
    seg_bytes.delete();
    for (int i = 0; i < 20; i++) seg_bytes.push_back(8'(8'hA0 + i));
    run_seg(0, 20, 0, 1, 0);
    chk("clamp_rx_count", rx_count, 16);

    // Randomized segments
    for (int it = 0; it < 32; it++) begin
      int disc, len, clen, need, n;
      bit ack, shrt;
      disc = $urandom_range(0, 3);
      len = $urandom_range(0, 20);
      ack = 1'($urandom_range(0, 1));
      clen = (len > 16) ? 16 : len;
      need = disc + clen + (ack ? 1 : 0);
      shrt = (it % 8 == 7) && (need > 0);
      n = shrt ? $urandom_range(0, need - 1) : need;
      seg_bytes.delete();
      for (int i = 0; i < n; i++) seg_bytes.push_back(8'($urandom_range(0, 255)));
      if (ack && !shrt) begin
        seg_bytes[need - 1] = ($urandom_range(0, 3) != 0) ? 8'h40
                             : (8'h40 ^ 8'($urandom_range(1, 255)));
      end
      run_seg(disc, len, ack, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/updi_response_handler.md
Name: updi_response_handler

Overview:
- Receive-side counterpart of the UPDI instruction queue handler. Drains the UART RX FIFO.
- UPDI is half-duplex, so the RX FIFO holds echoes of every transmitted byte. This block discards those echoes, collects the response data bytes (LD/LDCS/SIB), and checks the ACK byte (0x40).
- It pulses ack_received to the instruction queue handler. Each start executes one response segment.

Parameters:
- MAX_DATA_SIZE, 16, capacity of the response data buffer in bytes.
- LEN_BITS, $clog2(MAX_DATA_SIZE+1), width of resp_len and rx_count.
- DISCARD_BITS, 6, width of discard_len.
- TIMEOUT_CYCLES, 1024, maximum idle cycles waiting for an RX byte before abort.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a segment; sampled only when ready=1.
- ready  out  1  idle and able to accept start.
- discard_len  in  DISCARD_BITS  echo bytes to drop first; latched on start.
- resp_len  in  LEN_BITS  data bytes to collect; latched on start; values above MAX_DATA_SIZE are clamped to MAX_DATA_SIZE.
- expect_ack  in  1  read and check one ACK byte after the data; latched on start.
- fifo_data  in  8  RX FIFO read data; valid the cycle after a read strobe.
- fifo_rd_en  out  1  RX FIFO read strobe.
- fifo_empty  in  1  RX FIFO empty flag.
- data  out  8 x MAX_DATA_SIZE  collected response bytes; data[0] is the first received.
- rx_count  out  LEN_BITS  number of data bytes stored in the current or last segment.
- ack_received  out  1  one-cycle pulse on a valid ACK (0x40).
- done  out  1  one-cycle pulse on successful segment completion.
- err_bad_ack  out  1  one-cycle pulse when the ACK-slot byte is not 0x40.
- err_timeout  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset: state IDLE; ready=1; fifo_rd_en=0; all pulses 0; rx_count=0; data all 0x00; counters 0.
- States: IDLE, DISCARD, DATA, ACK.
- IDLE to active: start&&ready latches discard_len, resp_len (clamped) and expect_ack, clears rx_count, and enters the first non-empty phase. Phase order is DISCARD, then DATA, then ACK; a phase with zero count is skipped.
  - ready=0 from the cycle after start until return to IDLE.
  - If all counts are 0 and expect_ack=0, stay in IDLE and pulse done the cycle after start.
- Byte read (all active states): fifo_rd_en=1 for one cycle when !fifo_empty and no read is outstanding. The byte is consumed from fifo_data on the following cycle. Throughput is at most 1 byte per 2 cycles. fifo_rd_en is never asserted while fifo_empty=1.
- DISCARD: each consumed byte decrements the remaining discard count. The contents of discarded bytes are not checked.
- DATA: the consumed byte is written to data[rx_count], then rx_count increments. Previous contents beyond rx_count are left unchanged.
- ACK: if the consumed byte is 0x40, pulse ack_received and done in the same cycle; otherwise pulse err_bad_ack. Both cases go to IDLE.
- Segment end without ACK: after the last data byte is consumed with expect_ack=0, pulse done and go to IDLE.
- Timeout:
  - The counter clears on start and on every consumed byte, and increments each active cycle with no consumption.
  - When it reaches TIMEOUT_CYCLES-1: pulse err_timeout, go to IDLE, and discard any outstanding read (byte dropped).
  - data and rx_count keep their partial values.
- start while ready=0 is ignored.
- Asynchronous reset mid-segment forces reset values immediately.

Test Plan:
- Reset, then start with discard=2, resp_len=0, expect_ack=1. FIFO preloaded 0x55, 0x44, 0x40 -> two bytes dropped; ack_received and done pulse once; ready=1; rx_count=0.
- LDCS: discard=2, resp_len=1, expect_ack=0. FIFO 0x55, 0x80, 0x30 -> data[0]=0x30; rx_count=1; done pulse; no ack_received.
- SIB: discard=2, resp_len=16. FIFO echoes followed by 0x00..0x0F -> data[i]=i for all i; rx_count=16; fifo_rd_en never high while fifo_empty; FIFO empty at done.
- Bad ACK: discard=0, expect_ack=1, FIFO 0x41 -> err_bad_ack pulse; no ack_received, no done; ready=1.
- Starved FIFO: resp_len=2, only 0xAA written -> data[0]=0xAA; err_timeout exactly TIMEOUT_CYCLES-1 idle cycles after consumption; rx_count=1; ready=1.
- Reset mid-DATA (rst low for one cycle) -> ready=1 and rx_count=0 immediately; a start pulse while busy has no effect; resp_len=20 is clamped to 16.
